led_pulse_stretcher: RTL and testbench

Output-side complement to the button input conditioning. It turns single-cycle game event strobes (hit, miss, mole spawn) into human-visible LED flashes of guaranteed minimum on-time. It also enforces a guaranteed off-gap, so that back-to-back events show as separate flashes. The block sits between the game FSM and the board LED pins, with N independent channels.

---
 rtl/led_pulse_stretcher_pkg.sv | 30 +++
 rtl/led_pulse_stretcher_channel.sv | 123 ++++++++++++
 rtl/led_pulse_stretcher.sv | 56 +++++
 tb/tb_led_pulse_stretcher.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/led_pulse_stretcher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pulse_stretcher_pkg
// Description : Shared types and elaboration helpers for the LED pulse
//               stretcher: per-channel state encoding and counter range check.
// Revision    : 1.0  initial release
// ============================================================================
package led_pulse_stretcher_pkg;

  // Per-channel flash state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } stretch_state_t;

  // Widest counter the range helper can evaluate without overflow.
  localparam int MAX_CNT_WIDTH = 31;

  // A duration of CYCLES fits a WIDTH-bit counter when 1 <= CYCLES <= 2^WIDTH,
  // because the counter only ever has to reach CYCLES-1.
  function automatic bit cycles_in_range(input longint cycles, input int width);
    if (width < 1 || width > MAX_CNT_WIDTH) begin
      return 1'b0;
    end
    return (cycles >= 1) && (cycles <= (longint'(1) << width));
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pulse_stretcher_channel.sv
`default_nettype none
// ============================================================================
// Module      : stretch_channel
// Description : One LED channel: IDLE/ON/GAP state machine, duration counter
//               and single-deep pending flag.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   trig  in  event strobe
//   led   out stretched LED drive (registered)
//   busy  out channel in ON or GAP (registered)
//   drop  out one-cycle pulse when a trigger is discarded (registered)
// Revision    : 1.0  initial release
// ============================================================================
module stretch_channel
  import led_pulse_stretcher_pkg::*;
#(
  parameter int HOLD_CYCLES = 255,
  parameter int GAP_CYCLES  = 63,
  parameter int CNT_WIDTH   = 8,
  parameter int RETRIGGER   = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  output logic led,
  output logic busy,
  output logic drop
);

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam bit                   RETRIG_EN = (RETRIGGER != 0);

  stretch_state_t       state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 led_q, led_d;
  logic                 busy_q, busy_d;
  logic                 drop_q, drop_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    drop_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
      end

      ST_ON: begin
        // A restart wins over the end-of-hold transition, so a trigger on
        // the final ON cycle extends the flash instead of ending it.
        if (trig && RETRIG_EN) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (trig && !RETRIG_EN) begin
          if (pend_q) drop_d = 1'b1;
          else        pend_d = 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          // A trigger here is consumed directly; it never lands in pending.
          cnt_d  = '0;
          pend_d = 1'b0;
          if (pend_q || trig) state_d = ST_ON;
          else                state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (trig) begin
            if (pend_q) drop_d = 1'b1;
            else        pend_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase

    // Outputs follow the next state so they are registered alongside it.
    led_d  = (state_d == ST_ON);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign drop = drop_q;

endmodule
`default_nettype wire

// File: rtl/led_pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module      : led_pulse_stretcher
// Description : N_CH independent LED pulse stretchers turning single-cycle
//               event strobes into flashes with a minimum on-time and a
//               forced off-gap.
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   trig  in  [N_CH] event strobes
//   led   out [N_CH] stretched LED drive (registered)
//   busy  out [N_CH] channel in ON or GAP (registered)
//   drop  out [N_CH] discarded-trigger pulses (registered)
// Revision    : 1.0  initial release
// ============================================================================
module led_pulse_stretcher
  import led_pulse_stretcher_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int HOLD_CYCLES = 255,
  parameter int GAP_CYCLES  = 63,
  parameter int CNT_WIDTH   = 8,
  parameter int RETRIGGER   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] trig,
  output logic [N_CH-1:0] led,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] drop
);

  if (!cycles_in_range(longint'(HOLD_CYCLES), CNT_WIDTH)) begin : g_bad_hold
    $fatal(1, "led_pulse_stretcher: HOLD_CYCLES out of range for CNT_WIDTH");
  end
  if (!cycles_in_range(longint'(GAP_CYCLES), CNT_WIDTH)) begin : g_bad_gap
    $fatal(1, "led_pulse_stretcher: GAP_CYCLES out of range for CNT_WIDTH");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    stretch_channel #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES),
      .CNT_WIDTH   (CNT_WIDTH),
      .RETRIGGER   (RETRIGGER)
    ) u_channel (
      .clk   (clk),
      .rst_n (rst_n),
      .trig  (trig[i]),
      .led   (led[i]),
      .busy  (busy[i]),
      .drop  (drop[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pulse_stretcher
// Description : Directed bench for led_pulse_stretcher (HOLD=4, GAP=2, 4 ch).
//               dut0 queues re-triggers, dut1 restarts on re-trigger.
// Revision    : 1.0  initial release
// ============================================================================
module tb_led_pulse_stretcher;

  logic       clk;
  logic       rst_n;
  logic [3:0] trig0, led0, busy0, drop0;
  logic [3:0] trig1, led1, busy1, drop1;

  int n_checks;
  int n_fail;

  led_pulse_stretcher #(
    .N_CH(4), .HOLD_CYCLES(4), .GAP_CYCLES(2), .CNT_WIDTH(8), .RETRIGGER(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .trig(trig0), .led(led0), .busy(busy0), .drop(drop0)
  );

  led_pulse_stretcher #(
    .N_CH(4), .HOLD_CYCLES(4), .GAP_CYCLES(2), .CNT_WIDTH(8), .RETRIGGER(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .trig(trig1), .led(led1), .busy(busy1), .drop(drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  function automatic bit rng(input int c, input int a, input int b);
    return (c >= a) && (c <= b);
  endfunction

  // Run 0 (dut0): ch0 {10}, ch1 {10,12}, ch2 {10,12,13}, ch3 {10,16}
  // Run 1 (dut1): ch0 {10,12}, ch1 {10}
  // Run 2 (dut0): trig=4'b0101 at 10
  function automatic logic [3:0] stim(input int run, input int c);
    logic [3:0] t;
    t = 4'b0000;
    case (run)
      0: begin
        t[0] = (c == 10);
        t[1] = (c == 10) || (c == 12);
        t[2] = (c == 10) || (c == 12) || (c == 13);
        t[3] = (c == 10) || (c == 16);
      end
      1: begin
        t[0] = (c == 10) || (c == 12);
        t[1] = (c == 10);
      end
      default: begin
        t = (c == 10) ? 4'b0101 : 4'b0000;
      end
    endcase
    return t;
  endfunction

  // kind: 0 = led, 1 = busy, 2 = drop. Hand-computed from HOLD=4, GAP=2.
  function automatic logic [3:0] expv(input int run, input int kind, input int c);
    logic [3:0] e;
    logic       two_flash;
    e = 4'b0000;
    two_flash = rng(c, 11, 14) || rng(c, 17, 20);
    case (run)
      0: begin
        case (kind)
          0: e = {two_flash, two_flash, two_flash, rng(c, 11, 14)};
          1: e = {rng(c, 11, 22), rng(c, 11, 22), rng(c, 11, 22), rng(c, 11, 16)};
          default: e = {1'b0, (c == 14), 2'b00};
        endcase
      end
      1: begin
        case (kind)
          0: e = {2'b00, rng(c, 11, 14), rng(c, 11, 16)};
          1: e = {2'b00, rng(c, 11, 16), rng(c, 11, 18)};
          default: e = 4'b0000;
        endcase
      end
      default: begin
        case (kind)
          0: e = {1'b0, rng(c, 11, 14), 1'b0, rng(c, 11, 14)};
          1: e = {1'b0, rng(c, 11, 16), 1'b0, rng(c, 11, 16)};
          default: e = 4'b0000;
        endcase
      end
    endcase
    return e;
  endfunction

  // Leaves the bench 1 time unit after a rising edge with reset released;
  // that clock period is cycle 0.
  task automatic do_reset();
    trig0 = 4'b0000;
    trig1 = 4'b0000;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_scn(input int run);
    do_reset();
    for (int c = 0; c < 26; c++) begin
      if (run == 1) trig1 = stim(run, c);
      else          trig0 = stim(run, c);
      @(negedge clk);
      if (run == 1) begin
        check($sformatf("r%0d c%0d led", run, c),  led1,  expv(run, 0, c));
        check($sformatf("r%0d c%0d busy", run, c), busy1, expv(run, 1, c));
        check($sformatf("r%0d c%0d drop", run, c), drop1, expv(run, 2, c));
      end else begin
        check($sformatf("r%0d c%0d led", run, c),  led0,  expv(run, 0, c));
        check($sformatf("r%0d c%0d busy", run, c), busy0, expv(run, 1, c));
        check($sformatf("r%0d c%0d drop", run, c), drop0, expv(run, 2, c));
      end
      @(posedge clk);
      #1;
    end
    trig0 = 4'b0000;
    trig1 = 4'b0000;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    trig0    = 4'hF;
    trig1    = 4'hF;

    // Triggers held while in reset must have no effect.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst led0",  led0,  4'b0000);
    check("rst busy0", busy0, 4'b0000);
    check("rst drop0", drop0, 4'b0000);
    check("rst led1",  led1,  4'b0000);
    check("rst busy1", busy1, 4'b0000);
    check("rst drop1", drop1, 4'b0000);

    // Asynchronous reset in the middle of a flash.
    do_reset();
    trig0 = 4'b0001;
    @(posedge clk);
    #1 trig0 = 4'b0000;
    @(negedge clk);
    check("pre-async led0",  led0,  4'b0001);
    check("pre-async busy0", busy0, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    check("async led0",  led0,  4'b0000);
    check("async busy0", busy0, 4'b0000);

    run_scn(0);
    run_scn(1);
    run_scn(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
